stride_prefetcher: RTL

Parametrised stream/stride prefetch engine that sits beside the per-core cache hierarchy and issues prefetch requests toward L3 on behalf of L2. It trains a small stream table on the CPU access stream, detects constant-stride patterns (positive or negative) per stream, and emits a configurable burst of prefetch addresses over a valid/ready port. A next-line mode and an off mode are selectable at run time. Hit/miss accounting stays in the cache blocks; this block counts only its own prefetch activity.

---
 rtl/stride_prefetcher.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/stride_prefetcher.sv
// Stream/stride prefetch engine: trains a small stream table on CPU accesses
// and issues bursts of prefetch addresses over a valid/ready port.
module stride_prefetcher #(
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_STREAMS = 4,
  parameter int DEGREE      = 2,
  parameter int MAX_STRIDE  = 8,
  parameter int CONF_THRESH = 2,
  parameter int CONF_MAX    = 3,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   acc_valid,
  input  logic [ADDR_WIDTH-1:0]  acc_addr,
  output logic                   pf_valid,
  output logic [ADDR_WIDTH-1:0]  pf_addr,
  input  logic                   pf_ready,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pf_issued,
  output logic [COUNT_WIDTH-1:0] pf_dropped,
  output logic [COUNT_WIDTH-1:0] stream_allocs
);

  localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;
  localparam int CW = (CONF_MAX > 0) ? $clog2(CONF_MAX + 1) : 1;
  localparam int RW = $clog2(DEGREE + 1);
  localparam logic signed [ADDR_WIDTH-1:0] MAX_POS = ADDR_WIDTH'(MAX_STRIDE);
  localparam logic signed [ADDR_WIDTH-1:0] MAX_NEG = ADDR_WIDTH'(-MAX_STRIDE);
  localparam logic [CW-1:0] CONF_MAX_C = CW'(CONF_MAX);
  localparam logic [CW-1:0] THRESH_C   = CW'(CONF_THRESH);

  typedef enum logic {IDLE, ISSUE} state_t;

  logic                         valid_q  [NUM_STREAMS];
  logic [ADDR_WIDTH-1:0]        last_q   [NUM_STREAMS];
  logic signed [ADDR_WIDTH-1:0] stride_q [NUM_STREAMS];
  logic [CW-1:0]                conf_q   [NUM_STREAMS];
  logic [IW-1:0]                vptr_q;

  logic signed [ADDR_WIDTH-1:0] delta    [NUM_STREAMS];
  logic [CW-1:0]                conf_inc [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]       hit, ramp;

  logic                         train, match_any, free_any, alloc, trigger;
  logic [IW-1:0]                match_idx, free_idx, alloc_idx;
  logic signed [ADDR_WIDTH-1:0] burst_step;

  state_t                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        base_q, base_d;
  logic signed [ADDR_WIDTH-1:0] step_q, step_d;
  logic [RW-1:0]                remain_q, remain_d;
  logic                         handshake, drop;
  logic [COUNT_WIDTH-1:0]       issued_q, dropped_q, allocs_q;

  // Per-entry delta, match window and "this access completes a confident ramp".
  for (genvar gi = 0; gi < NUM_STREAMS; gi++) begin : g_entry
    assign delta[gi]    = $signed(acc_addr - last_q[gi]);
    assign hit[gi]      = valid_q[gi] && (delta[gi] <= MAX_POS) && (delta[gi] >= MAX_NEG);
    assign conf_inc[gi] = (conf_q[gi] == CONF_MAX_C) ? conf_q[gi] : conf_q[gi] + CW'(1);
    assign ramp[gi]     = (delta[gi] != '0) && (delta[gi] == stride_q[gi]) &&
                          (conf_inc[gi] >= THRESH_C);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q[gi]  <= 1'b0;
        last_q[gi]   <= '0;
        stride_q[gi] <= '0;
        conf_q[gi]   <= '0;
      end else if (train) begin
        if (match_any && match_idx == IW'(gi)) begin
          if (delta[gi] != '0) begin
            last_q[gi] <= acc_addr;
            if (delta[gi] == stride_q[gi]) begin
              conf_q[gi] <= conf_inc[gi];
            end else begin
              stride_q[gi] <= delta[gi];
              conf_q[gi]   <= '0;
            end
          end
        end else if (alloc && alloc_idx == IW'(gi)) begin
          valid_q[gi]  <= 1'b1;
          last_q[gi]   <= acc_addr;
          stride_q[gi] <= '0;
          conf_q[gi]   <= '0;
        end
      end
    end
  end

  // Descending scan so the lowest matching / free index is the one kept.
  always_comb begin
    train     = acc_valid && (mode != 2'd0);
    match_any = 1'b0;
    match_idx = '0;
    free_any  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_any = 1'b1;
        match_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
    alloc     = train && !match_any;
    alloc_idx = free_any ? free_idx : vptr_q;
    if (mode == 2'd1) begin
      trigger    = train;
      burst_step = ADDR_WIDTH'(1);
    end else begin
      trigger    = train && match_any && ramp[match_idx];
      burst_step = stride_q[match_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vptr_q <= '0;
    end else if (alloc && !free_any) begin
      vptr_q <= (vptr_q == IW'(NUM_STREAMS - 1)) ? '0 : vptr_q + IW'(1);
    end
  end

  assign busy      = (state_q == ISSUE);
  assign pf_valid  = busy;
  assign pf_addr   = busy ? base_q + step_q : '0;
  assign handshake = busy && pf_ready;

  // A trigger landing on the final handshake starts the next burst seamlessly.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    step_d   = step_q;
    remain_d = remain_q;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d  = ISSUE;
          base_d   = acc_addr;
          step_d   = burst_step;
          remain_d = RW'(DEGREE);
        end
      end
      ISSUE: begin
        if (handshake) begin
          base_d   = pf_addr;
          remain_d = remain_q - RW'(1);
          if (remain_q == RW'(1)) state_d = IDLE;
        end
        if (trigger) begin
          if (handshake && remain_q == RW'(1)) begin
            state_d  = ISSUE;
            base_d   = acc_addr;
            step_d   = burst_step;
            remain_d = RW'(DEGREE);
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      step_q    <= '0;
      remain_q  <= '0;
      issued_q  <= '0;
      dropped_q <= '0;
      allocs_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      step_q   <= step_d;
      remain_q <= remain_d;
      if (handshake) issued_q <= issued_q + COUNT_WIDTH'(1);
      if (drop)      dropped_q <= dropped_q + COUNT_WIDTH'(DEGREE);
      if (alloc)     allocs_q <= allocs_q + COUNT_WIDTH'(1);
    end
  end

  assign pf_issued     = issued_q;
  assign pf_dropped    = dropped_q;
  assign stream_allocs = allocs_q;

endmodule
